// File: rtl/gray_code_pkg.sv
// gray_code_pkg: mode constants and width-agnostic binary/Gray helper functions.
package gray_code_pkg;
  localparam logic GRAY_MODE_B2G = 1'b0;
  localparam logic GRAY_MODE_G2B = 1'b1;
  localparam int MAX_WIDTH = 32;
  // Callers zero-extend narrower words into 32 bits; the unused upper bits stay zero through all three functions.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [5:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH; i++) n = n + 6'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/gray_code_core.sv
// gray_code_core: combinational binary<->Gray conversion selected by mode.
module gray_code_core
  import gray_code_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [MAX_WIDTH-1:0] wide;
  assign wide = MAX_WIDTH'(din);
  assign dout = WIDTH'(mode == GRAY_MODE_G2B ? gray2bin(wide) : bin2gray(wide));
endmodule

// File: rtl/gray_code.sv
// gray_code: registered binary<->Gray converter with valid qualifier.
// GRAY_ADJ_CHECK_EN adds adj_err, flagging Gray words that are not exactly one bit from the previous one.
module gray_code
  import gray_code_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
`ifdef GRAY_ADJ_CHECK_EN
  output logic             adj_err,
`endif
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] conv;
  gray_code_core #(.WIDTH(WIDTH)) u_core (.mode(mode), .din(din), .dout(conv));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) dout <= conv;
    end
  end
`ifdef GRAY_ADJ_CHECK_EN
  logic [WIDTH-1:0] hist;
  logic             hist_vld;
  logic [WIDTH-1:0] gray_new;
  assign gray_new = mode == GRAY_MODE_G2B ? din : conv;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist     <= '0;
      hist_vld <= 1'b0;
      adj_err  <= 1'b0;
    end else begin
      adj_err <= in_valid && hist_vld && popcount(MAX_WIDTH'(hist ^ gray_new)) != 6'd1;
      if (in_valid) begin
        hist     <= gray_new;
        hist_vld <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_gray_code.sv
// tb_gray_code: directed self-checking bench for gray_code (WIDTH = 4).
module tb_gray_code;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       mode;
  logic [3:0] din;
  logic       out_valid;
  logic [3:0] dout;
`ifdef GRAY_ADJ_CHECK_EN
  logic       adj_err;
`endif
  int checks = 0;
  int errors = 0;
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_code #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .din(din),
    .out_valid(out_valid),
`ifdef GRAY_ADJ_CHECK_EN
    .adj_err(adj_err),
`endif
    .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic m, input logic [3:0] d);
    in_valid = v;
    mode     = m;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    step(1'b1, 1'b0, 4'b1001);
    chk("legacy_dout", 32'(dout), 32'b1101);
    chk("legacy_valid", 32'(out_valid), 32'h1);
    step(1'b1, 1'b1, 4'b1101);
    chk("inv_1101", 32'(dout), 32'b1001);
    step(1'b1, 1'b1, 4'b1000);
    chk("inv_1000", 32'(dout), 32'b1111);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'(i));
      chk($sformatf("b2g_%0d", i), 32'(dout), 32'(gtab[i]));
      chk($sformatf("b2g_valid_%0d", i), 32'(out_valid), 32'h1);
    end
    step(1'b0, 1'b0, 4'h0);
    chk("b2g_after_valid", 32'(out_valid), 32'h0);
    chk("b2g_after_hold", 32'(dout), 32'h8);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, gtab[i]);
      chk($sformatf("g2b_%0d", i), 32'(dout), 32'(i));
      chk($sformatf("g2b_valid_%0d", i), 32'(out_valid), 32'h1);
    end
    step(1'b0, 1'b1, 4'h5);
    chk("g2b_after_valid", 32'(out_valid), 32'h0);
    step(1'b1, 1'b0, 4'b0011);
    chk("hold_load", 32'(dout), 32'b0010);
    step(1'b0, 1'b0, 4'b1111);
    chk("hold_valid", 32'(out_valid), 32'h0);
    chk("hold_dout", 32'(dout), 32'b0010);
    step(1'b0, 1'b1, 4'b0110);
    chk("hold_dout2", 32'(dout), 32'b0010);
    step(1'b1, 1'b0, 4'b0101);
    chk("pre_rst_dout", 32'(dout), 32'b0111);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dout", 32'(dout), 32'h0);
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, 1'b0, 4'b0110);
    chk("post_rst_idle_valid", 32'(out_valid), 32'h0);
    step(1'b1, 1'b0, 4'b0110);
    chk("post_rst_dout", 32'(dout), 32'b0101);
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    step(1'b1, 1'b0, 4'b1111);
    chk("all_ones", 32'(dout), 32'b1000);
`ifdef GRAY_ADJ_CHECK_EN
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("adj_reset", 32'(adj_err), 32'h0);
    step(1'b1, 1'b1, 4'b0000);
    chk("adj_first", 32'(adj_err), 32'h0);
    step(1'b1, 1'b1, 4'b0001);
    chk("adj_0001", 32'(adj_err), 32'h0);
    step(1'b1, 1'b1, 4'b0011);
    chk("adj_0011", 32'(adj_err), 32'h0);
    step(1'b1, 1'b1, 4'b0000);
    chk("adj_dist2", 32'(adj_err), 32'h1);
    step(1'b0, 1'b1, 4'b1111);
    chk("adj_idle", 32'(adj_err), 32'h0);
    step(1'b1, 1'b0, 4'b0000);
    chk("adj_dist0", 32'(adj_err), 32'h1);
    step(1'b1, 1'b0, 4'b0001);
    chk("adj_b2g_ok", 32'(adj_err), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b1, 4'b1111);
    chk("adj_first_after_rst", 32'(adj_err), 32'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
